// File: rtl/smi_pkg.sv
// Shared types and constants for the SMI (clause 22 MDIO) PHY responder.
// Holds the frame FSM state encoding, opcodes and register indices.
package smi_pkg;

    typedef enum logic [2:0] {
        PRE,
        ST,
        OP,
        PA,
        RA,
        TA,
        DAT,
        SKIP
    } smi_state_t;

    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] OP_WR = 2'b01;

    localparam logic [4:0] REG_BMCR = 5'd0;
    localparam logic [4:0] REG_BMSR = 5'd1;
    localparam logic [4:0] REG_ID1  = 5'd2;
    localparam logic [4:0] REG_ID2  = 5'd3;

    // Bit times left after a rejected frame (TA + 16 data bits).
    localparam int unsigned SKIP_BITS = 18;

    function automatic logic op_valid(input logic [1:0] op);
        return (op == OP_RD) || (op == OP_WR);
    endfunction

endpackage

// File: rtl/smi_sync_edge.sv
// Two-flop synchronisers for MDC and MDIO plus MDC rising-edge detect.
// Ports: clk, rst_n in; mdc_in, mdio_in async in; mdio, mdc_rise out.
module smi_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic mdc_in,
    input  logic mdio_in,
    output logic mdio,
    output logic mdc_rise
);

    // mdc_q[2] is the previous synchronised sample, used for edge detect.
    logic [2:0] mdc_q;
    logic [1:0] mdio_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdc_q  <= 3'b000;
            mdio_q <= 2'b11;
        end else begin
            mdc_q  <= {mdc_q[1:0], mdc_in};
            mdio_q <= {mdio_q[0], mdio_in};
        end
    end

    assign mdc_rise = mdc_q[1] & ~mdc_q[2];
    assign mdio     = mdio_q[1];

endmodule

// File: rtl/smi_phy_responder.sv
// Emulated clause 22 PHY: decodes MDC/MDIO frames, serves a 32x16 register file.
// Ports: clk_clk, reset_reset_n, smi_nPhyRst, smi_clk, smi_dio_i/o/oe,
// link_up, bmcr, reg_wr_strobe/addr/data.
module smi_phy_responder
    import smi_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter int unsigned PREAMBLE_LEN = 32,
    parameter logic [15:0] BMCR_RST     = 16'h3100,
    parameter logic [15:0] STATUS_BASE  = 16'h7849,
    parameter logic [15:0] PHY_ID1      = 16'h0022,
    parameter logic [15:0] PHY_ID2      = 16'h1619
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        smi_nPhyRst,
    input  logic        smi_clk,
    input  logic        smi_dio_i,
    output logic        smi_dio_o,
    output logic        smi_dio_oe,
    input  logic        link_up,
    output logic [15:0] bmcr,
    output logic        reg_wr_strobe,
    output logic [4:0]  reg_wr_addr,
    output logic [15:0] reg_wr_data
);

    localparam logic [5:0] PRE_MAX  = 6'(PREAMBLE_LEN);
    localparam logic [4:0] SKIP_END = 5'(SKIP_BITS - 1);

    logic        mdc_rise;
    logic        bit_in;
    logic        soft_rst;

    smi_state_t  state;
    smi_state_t  state_nx;
    logic [4:0]  cnt;
    logic [5:0]  pre_cnt;
    logic [1:0]  op;
    logic [1:0]  op_full;
    logic        is_rd;
    logic [4:0]  pa;
    logic [4:0]  ra;
    logic [15:0] sh;
    logic        dout;
    logic        wr_go;
    logic [15:0] wr_val;
    logic [15:0] rd_val;

    logic [15:0] bmcr_q;
    logic [15:0] gen_q [32];

    assign soft_rst = ~smi_nPhyRst;
    assign op_full  = {op[0], bit_in};
    assign wr_val   = {sh[14:0], bit_in};
    assign wr_go    = mdc_rise && (state == DAT) && !is_rd && (cnt == 5'd15);

    smi_sync_edge u_sync (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .mdc_in   (smi_clk),
        .mdio_in  (smi_dio_i),
        .mdio     (bit_in),
        .mdc_rise (mdc_rise)
    );

    // State register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= PRE;
        end else if (soft_rst) begin
            state <= PRE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        if (mdc_rise) begin
            unique case (state)
                PRE: if (pre_cnt == PRE_MAX && !bit_in) state_nx = ST;
                ST:  state_nx = bit_in ? OP : PRE;
                OP: begin
                    if (cnt == 5'd1)
                        state_nx = op_valid(op_full) ? PA : SKIP;
                end
                PA:  if (cnt == 5'd4) state_nx = RA;
                RA: begin
                    if (cnt == 5'd4)
                        state_nx = (pa == PHY_ADDR) ? TA : SKIP;
                end
                TA:  if (cnt == 5'd1) state_nx = DAT;
                // A read needs one extra event after bit 0 to release MDIO.
                DAT: begin
                    if ((is_rd && cnt == 5'd16) || (!is_rd && cnt == 5'd15))
                        state_nx = PRE;
                end
                SKIP: if (cnt == SKIP_END) state_nx = PRE;
                default: state_nx = PRE;
            endcase
        end
    end

    // Outputs: MDIO is only ever driven during the data phase of a read.
    always_comb begin
        smi_dio_oe = (state == DAT) && is_rd;
        smi_dio_o  = smi_dio_oe ? dout : 1'b1;
    end

    always_comb begin
        unique case (ra)
            REG_BMCR: rd_val = bmcr_q;
            REG_BMSR: rd_val = {STATUS_BASE[15:3], link_up, STATUS_BASE[1:0]};
            REG_ID1:  rd_val = PHY_ID1;
            REG_ID2:  rd_val = PHY_ID2;
            default:  rd_val = gen_q[ra];
        endcase
    end

    // Frame datapath: bit counters and shift registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cnt     <= '0;
            pre_cnt <= '0;
            op      <= '0;
            is_rd   <= 1'b0;
            pa      <= '0;
            ra      <= '0;
            sh      <= '0;
            dout    <= 1'b1;
        end else if (soft_rst) begin
            cnt     <= '0;
            pre_cnt <= '0;
            op      <= '0;
            is_rd   <= 1'b0;
            pa      <= '0;
            ra      <= '0;
            sh      <= '0;
            dout    <= 1'b1;
        end else if (mdc_rise) begin
            cnt <= (state_nx != state) ? 5'd0 : cnt + 5'd1;
            if (state == PRE) begin
                if (!bit_in)
                    pre_cnt <= '0;
                else if (pre_cnt != PRE_MAX)
                    pre_cnt <= pre_cnt + 6'd1;
            end else begin
                pre_cnt <= '0;
            end
            unique case (state)
                OP: begin
                    op <= op_full;
                    if (cnt == 5'd1) is_rd <= (op_full == OP_RD);
                end
                PA: pa <= {pa[3:0], bit_in};
                RA: ra <= {ra[3:0], bit_in};
                TA: begin
                    // Read data is frozen here for the whole data phase.
                    if (cnt == 5'd1 && is_rd) begin
                        sh   <= rd_val;
                        dout <= 1'b0;
                    end
                end
                DAT: begin
                    if (is_rd) begin
                        dout <= sh[15];
                        sh   <= {sh[14:0], 1'b0};
                    end else begin
                        sh <= wr_val;
                    end
                end
                default: ;
            endcase
        end
    end

    // Register file and write-commit report.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            bmcr_q        <= BMCR_RST;
            reg_wr_strobe <= 1'b0;
            reg_wr_addr   <= '0;
            reg_wr_data   <= '0;
            for (int i = 0; i < 32; i++) gen_q[i] <= '0;
        end else if (soft_rst) begin
            bmcr_q        <= BMCR_RST;
            reg_wr_strobe <= 1'b0;
            reg_wr_addr   <= '0;
            reg_wr_data   <= '0;
            for (int i = 0; i < 32; i++) gen_q[i] <= '0;
        end else begin
            reg_wr_strobe <= wr_go;
            if (wr_go) begin
                reg_wr_addr <= ra;
                reg_wr_data <= wr_val;
                if (ra == REG_BMCR) begin
                    // Bit 15 is a self-clearing soft reset of the PHY.
                    if (wr_val[15]) begin
                        bmcr_q <= BMCR_RST;
                        for (int i = 4; i < 32; i++) gen_q[i] <= '0;
                    end else begin
                        bmcr_q <= wr_val;
                    end
                end else if (ra > REG_ID2) begin
                    gen_q[ra] <= wr_val;
                end
            end
        end
    end

    assign bmcr = bmcr_q;

endmodule

// File: tb/tb_smi_phy_responder.sv
// Directed bench for smi_phy_responder: bit-bangs MDC/MDIO frames.
// Checks read data, turnaround, strobes, address filter and resets.
module tb_smi_phy_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        phy_rst_n = 1'b1;
    logic        mdc = 1'b0;
    logic        dio_i = 1'b1;
    logic        dio_o;
    logic        dio_oe;
    logic        link_up = 1'b1;
    logic [15:0] bmcr;
    logic        wr_stb;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;

    int checks = 0;
    int errors = 0;
    int n_wr = 0;
    logic [4:0]  last_a = '0;
    logic [15:0] last_d = '0;
    logic        oe_seen = 1'b0;

    always #5 clk = ~clk;

    smi_phy_responder dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .smi_nPhyRst   (phy_rst_n),
        .smi_clk       (mdc),
        .smi_dio_i     (dio_i),
        .smi_dio_o     (dio_o),
        .smi_dio_oe    (dio_oe),
        .link_up       (link_up),
        .bmcr          (bmcr),
        .reg_wr_strobe (wr_stb),
        .reg_wr_addr   (wr_addr),
        .reg_wr_data   (wr_data)
    );

    always @(negedge clk) begin
        if (wr_stb) begin
            n_wr   = n_wr + 1;
            last_a = wr_addr;
            last_d = wr_data;
        end
        if (dio_oe) oe_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, act, exp);
        end
    endtask

    // One MDC period of 10 clk; outputs are stable when this returns.
    task automatic pulse(input logic b);
        dio_i = b;
        repeat (5) @(negedge clk);
        mdc = 1'b1;
        repeat (5) @(negedge clk);
        mdc = 1'b0;
    endtask

    task automatic send(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) pulse(v[i]);
    endtask

    task automatic hdr(input int pre, input logic [1:0] op,
                       input logic [4:0] pa, input logic [4:0] ra);
        repeat (pre) pulse(1'b1);
        pulse(1'b0);
        pulse(1'b1);
        send({14'd0, op}, 2);
        send({11'd0, pa}, 5);
        send({11'd0, ra}, 5);
    endtask

    task automatic wr_frame(input int pre, input logic [4:0] pa,
                            input logic [4:0] ra, input logic [15:0] d);
        hdr(pre, 2'b01, pa, ra);
        pulse(1'b1);
        pulse(1'b0);
        send(d, 16);
    endtask

    task automatic rd_check(input string tag, input logic [4:0] ra,
                            input logic [15:0] exp);
        logic [15:0] d;
        d = '0;
        hdr(32, 2'b10, 5'd1, ra);
        pulse(1'b1);
        check({tag, "_ta1_oe"}, {31'd0, dio_oe}, 32'd0);
        pulse(1'b1);
        check({tag, "_ta2"}, {30'd0, dio_oe, dio_o}, 32'd2);
        for (int i = 0; i < 16; i++) begin
            pulse(1'b1);
            d = {d[14:0], dio_o};
        end
        check({tag, "_data"}, {16'd0, d}, {16'd0, exp});
        pulse(1'b1);
        check({tag, "_rel"}, {30'd0, dio_oe, dio_o}, 32'd1);
    endtask

    initial begin
        int w0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_o", {31'd0, dio_o}, 32'd1);
        check("rst_oe", {31'd0, dio_oe}, 32'd0);
        check("rst_stb", {31'd0, wr_stb}, 32'd0);
        check("rst_bmcr", {16'd0, bmcr}, 32'h3100);
        check("rst_wr", {11'd0, wr_addr, wr_data}, 32'd0);

        wr_frame(32, 5'd1, 5'd4, 16'hA5C3);
        check("wr4_n", n_wr, 1);
        check("wr4_a", {27'd0, last_a}, 32'd4);
        check("wr4_d", {16'd0, last_d}, 32'hA5C3);
        rd_check("rd4", 5'd4, 16'hA5C3);

        link_up = 1'b1;
        rd_check("bmsr_up", 5'd1, 16'h784D);
        link_up = 1'b0;
        rd_check("bmsr_dn", 5'd1, 16'h7849);
        rd_check("id1", 5'd2, 16'h0022);
        rd_check("id2", 5'd3, 16'h1619);

        // Read-only register: strobe still reported, content unchanged.
        wr_frame(32, 5'd1, 5'd2, 16'hFFFF);
        check("wr_id_n", n_wr, 2);
        check("wr_id_a", {27'd0, last_a}, 32'd2);
        rd_check("id1_ro", 5'd2, 16'h0022);

        // Foreign PHY address.
        oe_seen = 1'b0;
        hdr(32, 2'b10, 5'd5, 5'd4);
        repeat (18) pulse(1'b1);
        check("phy5_oe", {31'd0, oe_seen}, 32'd0);
        wr_frame(32, 5'd5, 5'd4, 16'h1111);
        check("phy5_wr_n", n_wr, 2);
        rd_check("after_phy5", 5'd4, 16'hA5C3);

        // Short preamble.
        oe_seen = 1'b0;
        wr_frame(31, 5'd1, 5'd5, 16'h1234);
        check("pre31_n", n_wr, 2);
        hdr(31, 2'b10, 5'd1, 5'd5);
        repeat (18) pulse(1'b1);
        check("pre31_oe", {31'd0, oe_seen}, 32'd0);
        rd_check("rd5_empty", 5'd5, 16'h0000);
        wr_frame(32, 5'd1, 5'd5, 16'h1234);
        check("pre32_n", n_wr, 3);
        rd_check("rd5", 5'd5, 16'h1234);

        // BMCR write and soft reset.
        wr_frame(32, 5'd1, 5'd0, 16'h1140);
        check("bmcr_wr", {16'd0, bmcr}, 32'h1140);
        w0 = n_wr;
        wr_frame(32, 5'd1, 5'd0, 16'h8000);
        check("bmcr_rst_n", n_wr, w0 + 1);
        check("bmcr_rst", {16'd0, bmcr}, 32'h3100);
        rd_check("rd4_clr", 5'd4, 16'h0000);
        rd_check("rd5_clr", 5'd5, 16'h0000);
        rd_check("rd0", 5'd0, 16'h3100);

        // PHY reset pin in the middle of a read.
        wr_frame(32, 5'd1, 5'd4, 16'hBEEF);
        wr_frame(32, 5'd1, 5'd0, 16'h0100);
        check("pre_prst_bmcr", {16'd0, bmcr}, 32'h0100);
        hdr(32, 2'b10, 5'd1, 5'd4);
        pulse(1'b1);
        pulse(1'b1);
        repeat (3) pulse(1'b1);
        check("mid_oe", {31'd0, dio_oe}, 32'd1);
        phy_rst_n = 1'b0;
        @(negedge clk);
        check("prst_oe", {30'd0, dio_oe, dio_o}, 32'd1);
        check("prst_bmcr", {16'd0, bmcr}, 32'h3100);
        repeat (3) @(negedge clk);
        phy_rst_n = 1'b1;
        @(negedge clk);
        rd_check("prst_rd4", 5'd4, 16'h0000);
        rd_check("prst_rd0", 5'd0, 16'h3100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
